r_encode_queue: RTL

R_ENCODE_QUEUE -- requirements
Module: r_encode_queue

---
 rtl/r_encode_queue_pkg.sv | 50 +++++
 rtl/r_encode_fifo.sv | 89 ++++++++
 rtl/r_encode_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/r_encode_queue_pkg.sv
// ----------------------------------------------------------------------------
// r_encode_queue_pkg
// Shared constants and helpers for MIPS R-type encoding: opcode and funct
// codes, the default instruction-memory base address, and small helpers
// used by the encoder (and any R-type decoder) so the two agree on
// field layout and funct values.
// ----------------------------------------------------------------------------
package r_encode_queue_pkg;

    localparam int          INSTR_W           = 32;
    localparam int          COUNT_OUT_W       = 5;

    localparam logic [5:0]  OPCODE_RTYPE      = 6'b000000;

    localparam logic [5:0]  FUNCT_ADD         = 6'b100000;
    localparam logic [5:0]  FUNCT_SUB         = 6'b100010;
    localparam logic [5:0]  FUNCT_SLLV        = 6'b000100;
    localparam logic [5:0]  FUNCT_SLT         = 6'b101010;
    localparam logic [5:0]  FUNCT_JR          = 6'b001000;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

    // Strobe vector layout used throughout: {add, sub, sllv, slt, jr}.
    typedef struct packed {
        logic add;
        logic sub;
        logic sllv;
        logic slt;
        logic jr;
    } op_strobes_t;

    // True when exactly one strobe is high.
    function automatic logic is_onehot5(input logic [4:0] v);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < 5; i++) begin
            ones = ones + {2'b00, v[i]};
        end
        return (ones == 3'd1);
    endfunction

    // Assemble an R-type word; shamt is always zero for the supported ops.
    function automatic logic [31:0] rtype_word(input logic [4:0] rs,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd,
                                               input logic [5:0] funct);
        return {OPCODE_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

endpackage

// File: rtl/r_encode_fifo.sv
// ----------------------------------------------------------------------------
// r_encode_fifo
// Power-of-two FIFO holding encoded instruction words.
// Ports:
//   clk         - clock, all state on rising edge
//   rst_n       - synchronous active-low reset of pointers and count
//   push_i      - write request (gated internally by in_ready_o)
//   wdata_i     - word to write at the tail
//   in_ready_o  - not full; depends only on the registered count
//   pop_i       - read request (gated internally by out_valid_o)
//   rdata_o     - head entry (don't-care when empty)
//   out_valid_o - not empty
//   count_o     - occupancy, one bit wider than the pointers
// Storage is not reset; only control state is.
// ----------------------------------------------------------------------------
module r_encode_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              in_ready_o,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              out_valid_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic              do_push;
    logic              do_pop;

    // Ready/valid come straight from the registered count, so a pop in the
    // same cycle never frees a slot for a push while full.
    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);

    assign do_push = push_i & in_ready_o;
    assign do_pop  = pop_i  & out_valid_o;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write port: data only, no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/r_encode_queue.sv
// ----------------------------------------------------------------------------
// r_encode_queue
// Encodes one-hot MIPS R-type requests (add/sub/sllv/slt/jr) into 32-bit
// instruction words and queues them for a consumer, tagging each emitted
// word with a running instruction-memory address.
// Ports:
//   clk, reset         - clock; synchronous active-low reset
//   in_valid/in_ready  - request handshake
//   add..jr            - one-hot op select
//   rs, rt, rd         - register fields
//   out_valid/out_ready- output handshake
//   out_instr          - encoded head word
//   out_addr           - address of out_instr; +4 per pop, wraps at 2^32
//   count              - FIFO occupancy
//   err                - sticky flag for requests with a bad op strobe set
// ----------------------------------------------------------------------------
module r_encode_queue
    import r_encode_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        add,
    input  logic        sub,
    input  logic        sllv,
    input  logic        slt,
    input  logic        jr,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic [4:0]  count,
    output logic        err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    op_strobes_t        ops;
    logic               legal;
    logic               accept;
    logic               pop;
    logic [5:0]         funct;
    logic [4:0]         rt_eff;
    logic [4:0]         rd_eff;
    logic [INSTR_W-1:0] enc_word;
    logic [CNT_W-1:0]   fifo_count;

    logic               err_q,  err_d;
    logic [31:0]        addr_q, addr_d;

    assign ops    = '{add: add, sub: sub, sllv: sllv, slt: slt, jr: jr};
    assign legal  = is_onehot5(ops);
    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Combinational encoder ahead of the FIFO write port. Only meaningful
    // when exactly one strobe is set; otherwise the word is never pushed.
    always_comb begin
        funct  = FUNCT_ADD;
        rt_eff = rt;
        rd_eff = rd;
        if (ops.sub) begin
            funct = FUNCT_SUB;
        end else if (ops.sllv) begin
            funct = FUNCT_SLLV;
        end else if (ops.slt) begin
            funct = FUNCT_SLT;
        end else if (ops.jr) begin
            funct  = FUNCT_JR;
            rt_eff = 5'd0;
            rd_eff = 5'd0;
        end
        enc_word = rtype_word(rs, rt_eff, rd_eff, funct);
    end

    r_encode_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (INSTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (in_valid & legal),
        .wdata_i     (enc_word),
        .in_ready_o  (in_ready),
        .pop_i       (out_ready),
        .rdata_o     (out_instr),
        .out_valid_o (out_valid),
        .count_o     (fifo_count)
    );

    assign count = COUNT_OUT_W'(fifo_count);

    // Illegal requests are still consumed (in_ready handshake completes),
    // they just never reach the FIFO.
    always_comb begin
        err_d  = err_q | (accept & ~legal);
        addr_d = pop ? (addr_q + 32'd4) : addr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q  <= 1'b0;
            addr_q <= BASE_ADDR;
        end else begin
            err_q  <= err_d;
            addr_q <= addr_d;
        end
    end

    assign err      = err_q;
    assign out_addr = addr_q;

endmodule
